// File: rtl/memory_unit_rv.sv
// Byte-addressable data/program memory with independent read and write channels,
// size-aware accesses, fault reporting, configurable read latency and an LR/SC reservation.
module memory_unit_rv #(
    parameter int XLEN            = 32,
    parameter int DEPTH_WORDS     = 1024,
    parameter int READ_LATENCY    = 1,
    parameter int MIN_ALIGN_BYTES = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_read_enable,
    input  logic [XLEN-1:0] in_read_address,
    input  logic [1:0]      in_read_size,
    input  logic            in_read_reserve,
    output logic            out_read_valid,
    output logic [XLEN-1:0] out_read_data,
    output logic            out_read_exception_valid,
    output logic [3:0]      out_read_exception,
    input  logic            in_write_enable,
    input  logic [XLEN-1:0] in_write_address,
    input  logic [XLEN-1:0] in_write_data,
    input  logic [1:0]      in_write_size,
    input  logic            in_write_conditional,
    output logic            out_write_valid,
    output logic            out_write_exception_valid,
    output logic [3:0]      out_write_exception,
    output logic            out_sc_fail,
    output logic            out_reservation_valid
);
    localparam int BYTES     = XLEN / 8;
    localparam int LANE_BITS = $clog2(BYTES);
    localparam int IDX_W     = $clog2(DEPTH_WORDS);
    localparam int WADDR_W   = XLEN - LANE_BITS;
    localparam int BADDR_W   = LANE_BITS + IDX_W;
    localparam logic [XLEN:0] MEM_BYTES = (XLEN + 1)'(DEPTH_WORDS * BYTES);

    localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] EXC_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] EXC_STORE_FAULT      = 4'd7;

    typedef enum logic [1:0] {ACC_OK, ACC_MISALIGNED, ACC_FAULT} acc_e;

    typedef struct packed {
        logic            valid;
        logic            exc_valid;
        logic [3:0]      exc;
        logic [XLEN-1:0] data;
    } rd_resp_t;

    // Misalignment is checked before the range so a misaligned access past the end reports misaligned.
    function automatic acc_e classify(input logic [XLEN-1:0] addr, input logic [1:0] size,
                                      input logic word_relaxed);
        logic [XLEN:0] last;
        logic [2:0]    mask;
        case (size)
            2'd0:    mask = 3'b000;
            2'd1:    mask = 3'b001;
            2'd2:    mask = word_relaxed ? 3'b001 : 3'b011;
            default: mask = 3'b111;
        endcase
        last = {1'b0, addr} + ((XLEN + 1)'(1) << size) - (XLEN + 1)'(1);
        if (size == 2'd3 && XLEN == 32)     return ACC_FAULT;
        if ((addr[2:0] & mask) != 3'b000)   return ACC_MISALIGNED;
        if (last >= MEM_BYTES)              return ACC_FAULT;
        return ACC_OK;
    endfunction

    logic [XLEN-1:0]    mem [DEPTH_WORDS];
    acc_e               rd_acc, wr_acc;
    logic [XLEN-1:0]    rd_bytes;
    logic [BADDR_W-1:0] rd_byte_addr;
    rd_resp_t           rd_new, stage1, rd_out;
    logic [WADDR_W-1:0] rd_word, wr_word, res_word, res_word_d;
    logic [BYTES-1:0]   wr_lanes;
    logic [XLEN-1:0]    wr_shifted;
    logic               res_valid, res_valid_d;
    logic               sc_ok, wr_commit, lr_set, wr_kills;

    assign rd_word = in_read_address[XLEN-1:LANE_BITS];
    assign wr_word = in_write_address[XLEN-1:LANE_BITS];

    // Bytes are gathered one at a time so a relaxed-alignment word read can straddle two storage words.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_acc       = classify(in_read_address, in_read_size, MIN_ALIGN_BYTES == 2);
        rd_bytes     = '0;
        rd_byte_addr = '0;
        for (int i = 0; i < BYTES; i++) begin
            rd_byte_addr = BADDR_W'(in_read_address + XLEN'(i));
            if (i < (1 << in_read_size))
                rd_bytes[i*8 +: 8] = mem[rd_byte_addr[LANE_BITS +: IDX_W]]
                                        [{rd_byte_addr[LANE_BITS-1:0], 3'b000} +: 8];
        end
        rd_new = '0;
        if (in_read_enable) begin
            rd_new.valid     = 1'b1;
            rd_new.exc_valid = (rd_acc != ACC_OK);
            rd_new.exc       = (rd_acc == ACC_MISALIGNED) ? EXC_LOAD_MISALIGNED :
                               (rd_acc == ACC_FAULT)      ? EXC_LOAD_FAULT : 4'd0;
            rd_new.data      = (rd_acc == ACC_OK) ? rd_bytes : '0;
        end
    end

    always_comb begin
        wr_acc     = classify(in_write_address, in_write_size, 1'b0);
        sc_ok      = res_valid && (res_word == wr_word) && (wr_acc == ACC_OK);
        wr_commit  = in_write_enable && (wr_acc == ACC_OK) && (!in_write_conditional || sc_ok);
        wr_lanes   = BYTES'(((1 << (1 << in_write_size)) - 1) << in_write_address[LANE_BITS-1:0]);
        wr_shifted = in_write_data << {in_write_address[LANE_BITS-1:0], 3'b000};
        // Any SC, or a legal plain store, can end the reservation; the clear beats a same-word LR.
        wr_kills    = in_write_enable && (in_write_conditional || wr_acc == ACC_OK);
        lr_set      = in_read_enable && in_read_reserve && (rd_acc == ACC_OK);
        res_valid_d = res_valid && !(wr_kills && (in_write_conditional || wr_word == res_word));
        res_word_d  = res_word;
        if (lr_set && !(wr_kills && wr_word == rd_word)) begin
            res_valid_d = 1'b1;
            res_word_d  = rd_word;
        end
    end

    // NOTE: storage is deliberately left out of reset so contents survive it and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int b = 0; b < BYTES; b++)
                if (wr_lanes[b])
                    mem[wr_word[IDX_W-1:0]][b*8 +: 8] <= wr_shifted[b*8 +: 8];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage1                    <= '0;
            res_valid                 <= 1'b0;
            res_word                  <= '0;
            out_write_valid           <= 1'b0;
            out_write_exception_valid <= 1'b0;
            out_write_exception       <= 4'd0;
            out_sc_fail               <= 1'b0;
        end else begin
            stage1                    <= rd_new;
            res_valid                 <= res_valid_d;
            res_word                  <= res_word_d;
            out_write_valid           <= in_write_enable;
            out_write_exception_valid <= in_write_enable && (wr_acc != ACC_OK);
            out_write_exception       <= !in_write_enable            ? 4'd0 :
                                         (wr_acc == ACC_MISALIGNED)  ? EXC_STORE_MISALIGNED :
                                         (wr_acc == ACC_FAULT)       ? EXC_STORE_FAULT : 4'd0;
            out_sc_fail               <= in_write_enable && in_write_conditional && !sc_ok;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        rd_resp_t stage2;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) stage2 <= '0;
            else       stage2 <= stage1;
        end
        assign rd_out = stage2;
    end else begin : g_lat1
        assign rd_out = stage1;
    end

    assign out_read_valid           = rd_out.valid;
    assign out_read_data            = rd_out.data;
    assign out_read_exception_valid = rd_out.exc_valid;
    assign out_read_exception       = rd_out.exc;
    assign out_reservation_valid    = res_valid;

endmodule

// File: tb/tb_memory_unit_rv.sv
// Scoreboard bench for memory_unit_rv: one instance per read latency, shared stimulus,
// expected responses queued at issue and checked by per-instance monitors.
module tb_memory_unit_rv;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_read_enable, in_read_reserve;
    logic [31:0] in_read_address;
    logic [1:0]  in_read_size;
    logic        in_write_enable, in_write_conditional;
    logic [31:0] in_write_address, in_write_data;
    logic [1:0]  in_write_size;

    logic        rv_l1, rxv_l1, wv_l1, wxv_l1, sf_l1, res_l1;
    logic [31:0] rd_l1;
    logic [3:0]  rx_l1, wx_l1;
    logic        rv_l2, rxv_l2, wv_l2, wxv_l2, sf_l2, res_l2;
    logic [31:0] rd_l2;
    logic [3:0]  rx_l2, wx_l2;

    typedef struct { logic xv; logic [3:0] x; logic [31:0] data; int due; } rd_exp_t;
    typedef struct { logic xv; logic [3:0] x; logic sf; int due; } wr_exp_t;
    rd_exp_t rq0[$], rq1[$];
    wr_exp_t wq0[$], wq1[$];

    int tests = 0, failures = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    memory_unit_rv #(.XLEN(32), .DEPTH_WORDS(1024), .READ_LATENCY(1), .MIN_ALIGN_BYTES(0)) dut_l1 (
        .clk(clk), .reset(reset),
        .in_read_enable(in_read_enable), .in_read_address(in_read_address),
        .in_read_size(in_read_size), .in_read_reserve(in_read_reserve),
        .out_read_valid(rv_l1), .out_read_data(rd_l1),
        .out_read_exception_valid(rxv_l1), .out_read_exception(rx_l1),
        .in_write_enable(in_write_enable), .in_write_address(in_write_address),
        .in_write_data(in_write_data), .in_write_size(in_write_size),
        .in_write_conditional(in_write_conditional),
        .out_write_valid(wv_l1), .out_write_exception_valid(wxv_l1),
        .out_write_exception(wx_l1), .out_sc_fail(sf_l1), .out_reservation_valid(res_l1));

    memory_unit_rv #(.XLEN(32), .DEPTH_WORDS(1024), .READ_LATENCY(2), .MIN_ALIGN_BYTES(0)) dut_l2 (
        .clk(clk), .reset(reset),
        .in_read_enable(in_read_enable), .in_read_address(in_read_address),
        .in_read_size(in_read_size), .in_read_reserve(in_read_reserve),
        .out_read_valid(rv_l2), .out_read_data(rd_l2),
        .out_read_exception_valid(rxv_l2), .out_read_exception(rx_l2),
        .in_write_enable(in_write_enable), .in_write_address(in_write_address),
        .in_write_data(in_write_data), .in_write_size(in_write_size),
        .in_write_conditional(in_write_conditional),
        .out_write_valid(wv_l2), .out_write_exception_valid(wxv_l2),
        .out_write_exception(wx_l2), .out_sc_fail(sf_l2), .out_reservation_valid(res_l2));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] s, input logic res,
                      input logic xv, input logic [3:0] x, input logic [31:0] d);
        in_read_enable  = 1'b1;
        in_read_address = a;
        in_read_size    = s;
        in_read_reserve = res;
        rq0.push_back('{xv: xv, x: x, data: d, due: cyc + 1});
        rq1.push_back('{xv: xv, x: x, data: d, due: cyc + 2});
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input logic cond, input logic xv, input logic [3:0] x, input logic sf);
        in_write_enable      = 1'b1;
        in_write_address     = a;
        in_write_data        = d;
        in_write_size        = s;
        in_write_conditional = cond;
        wq0.push_back('{xv: xv, x: x, sf: sf, due: cyc + 1});
        wq1.push_back('{xv: xv, x: x, sf: sf, due: cyc + 1});
    endtask

    task automatic step();
        @(negedge clk);
        in_read_enable       = 1'b0;
        in_read_reserve      = 1'b0;
        in_write_enable      = 1'b0;
        in_write_conditional = 1'b0;
    endtask

    task automatic check_res(input string name, input logic exp);
        check({name, "_L1"}, res_l1, exp);
        check({name, "_L2"}, res_l2, exp);
    endtask

    task automatic mon_rd(input int k, input logic [31:0] d, input logic xv, input logic [3:0] x);
        rd_exp_t e;
        string   tag = (k == 0) ? "L1" : "L2";
        if ((k == 0 && rq0.size() == 0) || (k == 1 && rq1.size() == 0)) begin
            check({"rd_unexpected_", tag}, 1'b1, 1'b0);
            return;
        end
        e = (k == 0) ? rq0.pop_front() : rq1.pop_front();
        check({"rd_latency_", tag}, 64'(cyc), 64'(e.due));
        check({"rd_data_", tag}, d, e.data);
        check({"rd_exc_", tag}, {xv, x}, {e.xv, e.x});
    endtask

    task automatic mon_wr(input int k, input logic xv, input logic [3:0] x, input logic sf);
        wr_exp_t e;
        string   tag = (k == 0) ? "L1" : "L2";
        if ((k == 0 && wq0.size() == 0) || (k == 1 && wq1.size() == 0)) begin
            check({"wr_unexpected_", tag}, 1'b1, 1'b0);
            return;
        end
        e = (k == 0) ? wq0.pop_front() : wq1.pop_front();
        check({"wr_latency_", tag}, 64'(cyc), 64'(e.due));
        check({"wr_resp_", tag}, {xv, x, sf}, {e.xv, e.x, e.sf});
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rv_l1) mon_rd(0, rd_l1, rxv_l1, rx_l1);
            if (rv_l2) mon_rd(1, rd_l2, rxv_l2, rx_l2);
            if (wv_l1) mon_wr(0, wxv_l1, wx_l1, sf_l1);
            if (wv_l2) mon_wr(1, wxv_l2, wx_l2, sf_l2);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        in_read_enable = 1'b0; in_read_reserve = 1'b0; in_read_address = '0; in_read_size = '0;
        in_write_enable = 1'b0; in_write_conditional = 1'b0; in_write_address = '0;
        in_write_data = '0; in_write_size = '0;
        repeat (2) @(negedge clk);
        check("reset_rv_L1", rv_l1, 1'b0);
        check("reset_rv_L2", rv_l2, 1'b0);
        check("reset_wv_L1", wv_l1, 1'b0);
        check("reset_wv_L2", wv_l2, 1'b0);
        check_res("reset_res", 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Sized reads of a stored word
        wr(32'h10, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 4'd0, 1'b0); step();
        rd(32'h11, 2'd0, 1'b0, 1'b0, 4'd0, 32'h0000_00BE); step();
        rd(32'h12, 2'd1, 1'b0, 1'b0, 4'd0, 32'h0000_DEAD); step();
        rd(32'h10, 2'd2, 1'b0, 1'b0, 4'd0, 32'hDEADBEEF); step();

        // Faults and boundaries
        rd(32'h12, 2'd2, 1'b0, 1'b1, 4'd4, 32'h0); step();
        wr(32'h13, 32'hFFFF, 2'd1, 1'b0, 1'b1, 4'd6, 1'b0); step();
        rd(32'h10, 2'd2, 1'b0, 1'b0, 4'd0, 32'hDEADBEEF); step();
        rd(32'h1000, 2'd2, 1'b0, 1'b1, 4'd5, 32'h0); step();
        rd(32'hFFF, 2'd1, 1'b0, 1'b1, 4'd4, 32'h0); step();
        rd(32'h0, 2'd3, 1'b0, 1'b1, 4'd5, 32'h0); step();
        wr(32'hFFC, 32'hCAFEF00D, 2'd2, 1'b0, 1'b0, 4'd0, 1'b0); step();
        rd(32'hFFC, 2'd2, 1'b0, 1'b0, 4'd0, 32'hCAFEF00D);
        wr(32'h1000, 32'h1, 2'd2, 1'b0, 1'b1, 4'd7, 1'b0); step();
        rd(32'hFFF, 2'd0, 1'b0, 1'b0, 4'd0, 32'h0000_00CA);
        wr(32'hFFE, 32'hFFFF, 2'd2, 1'b0, 1'b1, 4'd6, 1'b0); step();
        rd(32'hFFC, 2'd2, 1'b0, 1'b0, 4'd0, 32'hCAFEF00D); step();

        // LR then SC succeeds once, second SC fails
        wr(32'h40, 32'h11111111, 2'd2, 1'b0, 1'b0, 4'd0, 1'b0); step();
        rd(32'h40, 2'd2, 1'b1, 1'b0, 4'd0, 32'h11111111); step();
        check_res("lr_sets_res", 1'b1);
        wr(32'h40, 32'h1234, 2'd2, 1'b1, 1'b0, 4'd0, 1'b0); step();
        check_res("sc_clears_res", 1'b0);
        rd(32'h40, 2'd2, 1'b0, 1'b0, 4'd0, 32'h1234);
        wr(32'h40, 32'h5678, 2'd2, 1'b1, 1'b0, 4'd0, 1'b1); step();
        rd(32'h40, 2'd2, 1'b0, 1'b0, 4'd0, 32'h1234); step();

        // Plain store to the reserved word breaks the reservation
        rd(32'h40, 2'd2, 1'b1, 1'b0, 4'd0, 32'h1234); step();
        wr(32'h40, 32'hAAAA, 2'd2, 1'b0, 1'b0, 4'd0, 1'b0); step();
        check_res("store_clears_res", 1'b0);
        wr(32'h40, 32'hBBBB, 2'd2, 1'b1, 1'b0, 4'd0, 1'b1); step();
        rd(32'h40, 2'd2, 1'b0, 1'b0, 4'd0, 32'hAAAA); step();

        // Same-cycle LR with stores to other / same word
        rd(32'h40, 2'd2, 1'b1, 1'b0, 4'd0, 32'hAAAA);
        wr(32'h44, 32'h55, 2'd2, 1'b0, 1'b0, 4'd0, 1'b0); step();
        check_res("lr_other_word_store", 1'b1);
        rd(32'h40, 2'd2, 1'b1, 1'b0, 4'd0, 32'hAAAA);
        wr(32'h40, 32'h77, 2'd2, 1'b0, 1'b0, 4'd0, 1'b0); step();
        check_res("lr_same_word_store", 1'b0);
        wr(32'h40, 32'h99, 2'd2, 1'b1, 1'b0, 4'd0, 1'b1); step();
        rd(32'h40, 2'd2, 1'b0, 1'b0, 4'd0, 32'h77); step();

        // Faulting SC still clears, faulting LR does not set
        rd(32'h44, 2'd2, 1'b1, 1'b0, 4'd0, 32'h55); step();
        check_res("lr_44_sets", 1'b1);
        wr(32'h42, 32'h1, 2'd2, 1'b1, 1'b1, 4'd6, 1'b1); step();
        check_res("faulting_sc_clears", 1'b0);
        rd(32'h46, 2'd2, 1'b1, 1'b1, 4'd4, 32'h0); step();
        check_res("faulting_lr_no_set", 1'b0);

        // Read-first on same-cycle overlap, then a byte-lane store
        wr(32'h20, 32'h5, 2'd2, 1'b0, 1'b0, 4'd0, 1'b0); step();
        rd(32'h20, 2'd2, 1'b0, 1'b0, 4'd0, 32'h5);
        wr(32'h20, 32'h9, 2'd2, 1'b0, 1'b0, 4'd0, 1'b0); step();
        rd(32'h20, 2'd2, 1'b0, 1'b0, 4'd0, 32'h9); step();
        wr(32'h22, 32'hAB, 2'd0, 1'b0, 1'b0, 4'd0, 1'b0); step();
        rd(32'h20, 2'd2, 1'b0, 1'b0, 4'd0, 32'h00AB0009); step();
        repeat (3) step();

        // Reset in the middle of a read stream
        rd(32'h44, 2'd2, 1'b1, 1'b0, 4'd0, 32'h55); step();
        rd(32'h10, 2'd2, 1'b0, 1'b0, 4'd0, 32'hDEADBEEF); step();
        rd(32'h20, 2'd2, 1'b0, 1'b0, 4'd0, 32'h00AB0009);
        #2 reset = 1'b1;
        #1;
        check("midreset_rv_L1", rv_l1, 1'b0);
        check("midreset_rv_L2", rv_l2, 1'b0);
        check_res("midreset_res", 1'b0);
        rq0.delete(); rq1.delete(); wq0.delete(); wq1.delete();
        step();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_reset_rv_L1", rv_l1, 1'b0);
            check("post_reset_rv_L2", rv_l2, 1'b0);
        end
        check_res("post_reset_res", 1'b0);
        rd(32'h10, 2'd2, 1'b0, 1'b0, 4'd0, 32'hDEADBEEF); step();
        rd(32'h20, 2'd2, 1'b0, 1'b0, 4'd0, 32'h00AB0009); step();

        for (int i = 0; i < 10; i++) begin
            if (rq0.size() == 0 && rq1.size() == 0 && wq0.size() == 0 && wq1.size() == 0) break;
            step();
        end
        check("drain_rq_L1", 64'(rq0.size()), 64'd0);
        check("drain_rq_L2", 64'(rq1.size()), 64'd0);
        check("drain_wq_L1", 64'(wq0.size()), 64'd0);
        check("drain_wq_L2", 64'(wq1.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/memory_unit_rv.md
Name: memory_unit_rv

Overview:
- Parametrised successor to the 32-bit data memory: byte-addressable RAM with independent read and write channels.
- Adds size-aware accesses, byte lanes, separate read/write exception reporting, configurable read latency, and an LR/SC reservation station.
- Sits between the processor core's memRead/memWrite channels and on-chip storage. A second instance with MIN_ALIGN_BYTES=2 serves as program memory and supports compressed fetch.

Parameters:
XLEN, 32, data and address width in bits (32 or 64)
DEPTH_WORDS, 1024, number of XLEN-bit words of storage
READ_LATENCY, 1, cycles from read request to response (1 or 2)
MIN_ALIGN_BYTES, 0, alignment override for word reads: 0 = natural alignment, 2 = word reads only need 2-byte alignment (fetch use)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
in_read_enable  in  1  read request strobe; one request accepted per cycle, no backpressure
in_read_address  in  XLEN  byte address
in_read_size  in  2  0=byte, 1=half, 2=word, 3=dword (legal only if XLEN=64)
in_read_reserve  in  1  LR: set reservation on this read
out_read_valid  out  1  response strobe
out_read_data  out  XLEN  zero-extended, right-justified read data
out_read_exception_valid  out  1  read faulted
out_read_exception  out  4  4 = load misaligned, 5 = load access fault
in_write_enable  in  1  write request strobe
in_write_address  in  XLEN  byte address
in_write_data  in  XLEN  right-justified store data
in_write_size  in  2  encoded as in_read_size
in_write_conditional  in  1  SC: write only if reservation holds
out_write_valid  out  1  write completion strobe
out_write_exception_valid  out  1  write faulted
out_write_exception  out  4  6 = store misaligned, 7 = store access fault
out_sc_fail  out  1  valid with out_write_valid; 1 = SC did not write
out_reservation_valid  out  1  reservation station occupied

Behaviour:
- Reset (asynchronous):
  - All outputs to 0.
  - Read pipeline and write completion register flushed; in-flight responses are dropped, never emitted after reset deasserts.
  - Reservation cleared.
  - Storage contents are not reset and are retained across reset.
- Read channel, exception checks:
  - Request accepted when in_read_enable=1.
  - Size 3 with XLEN=32 -> code 5.
  - Misaligned if address mod (1<<size) != 0 -> code 4. With MIN_ALIGN_BYTES=2 and size=2, only address[0] is checked.
  - Out of range if any accessed byte >= DEPTH_WORDS*XLEN/8 -> code 5.
  - Misaligned takes priority over out of range.
- Read channel, response:
  - Response appears exactly READ_LATENCY cycles later: out_read_valid=1 for one cycle.
  - On fault: exception fields set and data=0.
  - Little-endian byte-lane extraction; a 2-byte-aligned word read spanning two storage words assembles both.
- Write channel:
  - Same checks, codes 7/6.
  - Legal write commits the addressed byte lanes at the accepting edge.
  - out_write_valid pulses the following cycle, with exception fields and out_sc_fail.
  - A faulting write never modifies storage.
- Same-cycle read and write to overlapping bytes: read-first. The read returns pre-write data for both latencies.
- Reservation station: holds a valid bit and an XLEN-aligned word address.
  - LR (legal read with in_read_reserve): sets valid and records the word address.
  - SC:
    - Writes only if valid=1 and the word address matches; out_sc_fail=0 on success.
    - Otherwise no write and out_sc_fail=1.
    - Every SC, including faulting ones, clears the reservation.
  - A non-conditional legal store to the reserved word clears the reservation.
  - Same-cycle LR and clearing store/SC to the same word: the clear wins, reservation ends invalid. LR to a different word wins.
  - A faulting LR does not set the reservation.
- Channels are independent: a read and a write may both be accepted every cycle. Throughput is 1 request/cycle per channel.

Test Plan:
- Write word 0xDEADBEEF @0x10, then read byte @0x11, half @0x12, word @0x10 -> 0xBE, 0xDEAD, 0xDEADBEEF, each valid READ_LATENCY cycles after its request.
- Read word @0x12 (MIN_ALIGN_BYTES=0) -> exception 4, data 0. Store half @0x13 -> exception 6, memory unchanged. Read @DEPTH_WORDS*4 -> exception 5.
- LR @0x40 then SC 0x1234 @0x40 -> sc_fail=0, read returns 0x1234. A second SC @0x40 -> sc_fail=1, data unchanged.
- LR @0x40, plain store @0x40, SC @0x40 -> sc_fail=1. LR @0x40 plus same-cycle store @0x44 -> reservation stays valid.
- Same-cycle read and write @0x20 (old value 5, new 9) -> read returns 5, next read returns 9. Repeat with READ_LATENCY=2.
- Issue reads on 3 consecutive cycles, assert reset mid-stream -> no out_read_valid after reset, reservation 0, previously written data intact after reset.
